// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC capture controller and its readout helper.
package tdc_pkg;

    localparam int unsigned TDC_DEPTH = 128;
    localparam int unsigned TDC_AW    = 8;
    localparam int unsigned TDC_DW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE,
        ST_READOUT
    } tdc_state_e;

endpackage

// File: rtl/tdc_rd_stream.sv
// Read pointer and valid/ready tracking for a RAM port with 1-cycle registered read latency.
module tdc_rd_stream #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          clear,
    input  logic [AW:0]   count,
    input  logic          out_ready,
    output logic          ren,
    output logic [AW-1:0] raddr,
    output logic          out_valid,
    output logic          finished
);

    logic [AW:0] rd_ptr;
    logic        more;

    assign more  = rd_ptr < count;
    // A new read is only issued when the word in the output slot is gone or leaving,
    // so ram_rdata stays frozen while the consumer stalls.
    assign ren      = en && more && (!out_valid || out_ready);
    assign raddr    = rd_ptr[AW-1:0];
    assign finished = en && !more && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (start) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (clear || !en) begin
            out_valid <= 1'b0;
        end else begin
            if (ren) begin
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdc_capture_ctrl.sv
// Sequences one TDC capture buffer: arm, trigger, write N samples, then stream them out.
module tdc_capture_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned DEPTH = TDC_DEPTH,
    parameter int unsigned AW    = TDC_AW,
    parameter int unsigned DW    = TDC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic [AW-1:0] num_samples,
    input  logic          trig,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          rd_start,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] count
);

    // One extra bit so a full-depth length and count are representable.
    localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);
    localparam logic [AW:0] One    = (AW+1)'(1);

    tdc_state_e  state_q, state_d;
    logic [AW:0] len_q, len_d, len_new;
    logic [AW:0] count_q, count_d;
    logic        busy_q, done_q;
    logic        rd_go, rd_finished;

    assign len_new = (num_samples == '0 || {1'b0, num_samples} > DepthL) ? DepthL
                                                                         : {1'b0, num_samples};

    assign ram_wen   = sample_valid &&
                       (state_q == ST_CAPTURE || (state_q == ST_ARMED && trig));
    assign ram_waddr = count_q[AW-1:0];
    assign ram_wdata = sample_data;
    assign out_data  = ram_rdata;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        rd_go   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        len_d   = len_new;
                        count_d = '0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (state_q == ST_ARMED && trig) state_d = ST_CAPTURE;
                    if (ram_wen) begin
                        count_d = count_q + One;
                        if (count_q == len_q - One) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        len_d   = len_new;
                        count_d = '0;
                    end else if (rd_start) begin
                        state_d = ST_READOUT;
                        rd_go   = 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (rd_finished) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            busy_q  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE) ||
                       (state_d == ST_READOUT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    tdc_rd_stream #(
        .AW(AW)
    ) u_rd_stream (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == ST_READOUT),
        .start    (rd_go),
        .clear    (abort),
        .count    (count_q),
        .out_ready(out_ready),
        .ren      (ram_ren),
        .raddr    (ram_raddr),
        .out_valid(out_valid),
        .finished (rd_finished)
    );

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Bench for tdc_capture_ctrl with a behavioural capture RAM and a queue of expected words.
module tb_tdc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trig, sample_valid, rd_start, out_ready;
    logic [7:0]  num_samples;
    logic [31:0] sample_data;
    logic        ram_wen, ram_ren, out_valid, busy, done;
    logic [7:0]  ram_waddr, ram_raddr, count;
    logic [31:0] ram_wdata, ram_rdata, out_data;

    logic [31:0] mem [256];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    tdc_capture_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .num_samples (num_samples),
        .trig        (trig),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .rd_start    (rd_start),
        .ram_wen     (ram_wen),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_ren     (ram_ren),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    task automatic run_capture(input logic [7:0] ns, input int exp_len,
                               input logic [31:0] base, input bit gapped);
        int written = 0;
        int cyc_n   = 0;
        exp_q.delete();
        @(negedge clk);
        num_samples = ns;
        arm = 1'b1;
        @(negedge clk);
        arm  = 1'b0;
        trig = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL armed_flags: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        while (written < exp_len && cyc_n < 1000) begin
            sample_valid = gapped ? (cyc_n % 2 == 0) : 1'b1;
            sample_data  = base + 32'(written);
            #1;
            n_checks++;
            if (ram_wen !== sample_valid) begin
                n_fail++;
                $display("FAIL cap_wen: cycle %0d ram_wen=%b, required %b", cyc_n, ram_wen,
                         sample_valid);
            end
            if (sample_valid) begin
                n_checks++;
                if (ram_waddr !== written[7:0] || ram_wdata !== sample_data) begin
                    n_fail++;
                    $display("FAIL cap_write: addr=%0d data=%h, required addr=%0d data=%h",
                             ram_waddr, ram_wdata, written, sample_data);
                end
                exp_q.push_back(sample_data);
                written++;
            end
            @(negedge clk);
            trig = 1'b0;
            cyc_n++;
        end
        sample_valid = 1'b1;
        sample_data  = 32'hdead_beef;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== exp_len[7:0]) begin
            n_fail++;
            $display("FAIL cap_done: wen=%b done=%b busy=%b count=%0d, required 0 1 0 %0d",
                     ram_wen, done, busy, count, exp_len);
        end
        sample_valid = 1'b0;
    endtask

    task automatic run_readout(input int stall_at, input int exp_count);
        int          popped = 0;
        int          stalls = 0;
        int          guard  = 0;
        logic [31:0] w;
        @(negedge clk);
        rd_start  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ram_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_first_ren: out_valid=%b ram_ren=%b, required 0 1", out_valid,
                     ram_ren);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_latency: out_valid=%b two cycles after rd_start, required 1",
                     out_valid);
        end
        while (exp_q.size() > 0 && guard < 1000) begin
            if (popped == stall_at && stalls < 3) begin
                out_ready = 1'b0;
                #1;
                n_checks++;
                if (out_valid !== 1'b1 || ram_ren !== 1'b0 || out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rd_stall: valid=%b ren=%b data=%h, required 1 0 %h",
                             out_valid, ram_ren, out_data, exp_q[0]);
                end
                stalls++;
            end else begin
                out_ready = 1'b1;
                #1;
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_gap: out_valid=%b with %0d words left, required 1",
                             out_valid, exp_q.size());
                end
                if (out_valid === 1'b1) begin
                    w = exp_q.pop_front();
                    n_checks++;
                    if (out_data !== w) begin
                        n_fail++;
                        $display("FAIL rd_data: word %0d got %h, required %h", popped,
                                 out_data, w);
                    end
                    popped++;
                end
            end
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_timeout: %0d words never delivered, required 0", exp_q.size());
        end
        exp_q.delete();
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || count !== exp_count[7:0]) begin
            n_fail++;
            $display("FAIL rd_end: done=%b out_valid=%b count=%0d, required 1 0 %0d", done,
                     out_valid, count, exp_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ram_wen, ram_ren, out_valid, busy, done} !== 5'b0 ||
            ram_waddr !== 8'd0 || ram_raddr !== 8'd0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: wen/ren/valid/busy/done=%b waddr=%0d raddr=%0d count=%0d, required all 0",
                     {ram_wen, ram_ren, out_valid, busy, done}, ram_waddr, ram_raddr, count);
        end
    endtask

    task automatic test_basic;
        run_capture(8'd4, 4, 32'h100, 1'b0);
        run_readout(-1, 4);
    endtask

    task automatic test_gapped;
        run_capture(8'd3, 3, 32'h200, 1'b1);
    endtask

    task automatic test_clamp;
        run_capture(8'd0, 128, 32'h1000, 1'b0);
        run_capture(8'd200, 128, 32'h2000, 1'b0);
    endtask

    task automatic test_backpressure;
        run_readout(5, 128);
    endtask

    task automatic test_trig_order;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort        = 1'b0;
        arm          = 1'b1;
        trig         = 1'b1;
        num_samples  = 8'd2;
        sample_valid = 1'b1;
        sample_data  = 32'ha0;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_with_arm: ram_wen=%b, required 0", ram_wen);
        end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            arm  = 1'b0;
            trig = 1'b0;
            #1;
            n_checks++;
            if (ram_wen !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL trig_wait: cycle %0d wen=%b busy=%b, required 0 1", k, ram_wen,
                         busy);
            end
        end
        @(negedge clk);
        trig        = 1'b1;
        sample_data = 32'ha5;
        #1;
        n_checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 8'd0 || ram_wdata !== 32'ha5) begin
            n_fail++;
            $display("FAIL trig_start: wen=%b addr=%0d data=%h, required 1 0 000000a5",
                     ram_wen, ram_waddr, ram_wdata);
        end
        @(negedge clk);
        trig        = 1'b0;
        sample_data = 32'ha6;
        #1;
        n_checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 8'd1) begin
            n_fail++;
            $display("FAIL trig_second: wen=%b addr=%0d, required 1 1", ram_wen, ram_waddr);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || count !== 8'd2) begin
            n_fail++;
            $display("FAIL trig_done: done=%b count=%0d, required 1 2", done, count);
        end
    endtask

    task automatic test_abort;
        @(negedge clk);
        num_samples = 8'd8;
        arm = 1'b1;
        @(negedge clk);
        arm          = 1'b0;
        trig         = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 32'h300;
        @(negedge clk);
        trig        = 1'b0;
        sample_data = 32'h301;
        @(negedge clk);
        sample_valid = 1'b0;
        abort        = 1'b1;
        @(negedge clk);
        abort        = 1'b0;
        sample_valid = 1'b1;
        trig         = 1'b1;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: wen=%b busy=%b done=%b, required 0 0 0", ram_wen, busy, done);
        end
        @(negedge clk);
        trig         = 1'b0;
        sample_valid = 1'b0;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_trig: wen=%b busy=%b, required 0 0", ram_wen, busy);
        end
    endtask

    task automatic test_rst_readout;
        run_capture(8'd4, 4, 32'h400, 1'b0);
        @(negedge clk);
        rd_start  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ram_wen, ram_ren, out_valid, busy, done} !== 5'b0 ||
            ram_waddr !== 8'd0 || ram_raddr !== 8'd0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_readout: wen/ren/valid/busy/done=%b waddr=%0d raddr=%0d count=%0d, required all 0",
                     {ram_wen, ram_ren, out_valid, busy, done}, ram_waddr, ram_raddr, count);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        trig         = 1'b0;
        sample_valid = 1'b0;
        rd_start     = 1'b0;
        out_ready    = 1'b0;
        num_samples  = 8'd0;
        sample_data  = 32'd0;
        test_reset();
        test_basic();
        test_gapped();
        test_clamp();
        test_backpressure();
        test_trig_order();
        test_abort();
        test_rst_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
